// File: rtl/cdc_xfer_arbiter.sv
// Round-robin arbiter feeding a toggle-handshake transfer into another clock domain.
// Optional ack watchdog: define CDC_XFER_TIMEOUT_EN to add the counter and timeout_err.
module cdc_xfer_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int SRC_W         = $clog2(NUM_REQ)
) (
  input  logic                      src_clk,
  input  logic                      src_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      xfer_req,
  output logic [DATA_W-1:0]         xfer_data,
  output logic [SRC_W-1:0]          xfer_src,
  input  logic                      xfer_ack_async,
  output logic                      xfer_done,
  output logic                      busy
`ifdef CDC_XFER_TIMEOUT_EN
  ,
  output logic                      timeout_err
`endif
);

  // state    | meaning
  // IDLE     | no transfer in flight, arbitrating among req_valid
  // WAIT_ACK | payload launched, waiting for synchronized ack to match xfer_req
  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [SRC_W-1:0]     rr_ptr;
  logic                 ack_s1, ack_s2;
  logic                 grant_found;
  logic [SRC_W-1:0]     grant_idx;
  logic [SRC_W:0]       cand_w;
  logic [SRC_W-1:0]     cand;
  logic [NUM_REQ-1:0]   grant_oh;
  logic [DATA_W-1:0]    grant_data;
  logic                 start_xfer;
  logic                 finish_xfer;
  logic                 timeout_hit;

`ifdef CDC_XFER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  // Search starts at rr_ptr and wraps, so the requester after the last grant wins ties.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_w      = '0;
    cand        = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_w = {1'b0, rr_ptr} + (SRC_W+1)'(off);
      if (cand_w >= (SRC_W+1)'(NUM_REQ)) begin
        cand_w = cand_w - (SRC_W+1)'(NUM_REQ);
      end
      cand = cand_w[SRC_W-1:0];
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    grant_oh   = '0;
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        grant_oh[i] = 1'b1;
        grant_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    start_xfer  = 1'b0;
    finish_xfer = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          start_xfer = 1'b1;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s2 == xfer_req) begin
          finish_xfer = 1'b1;
          state_d     = IDLE;
        end
`ifdef CDC_XFER_TIMEOUT_EN
        else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          finish_xfer = 1'b1;
          state_d     = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge src_clk) begin
    if (src_rst) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      ack_s1    <= 1'b0;
      ack_s2    <= 1'b0;
      xfer_req  <= 1'b0;
      xfer_data <= '0;
      xfer_src  <= '0;
      req_ready <= '0;
      xfer_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_s1    <= xfer_ack_async;
      ack_s2    <= ack_s1;
      req_ready <= '0;
      xfer_done <= finish_xfer;
      if (start_xfer) begin
        req_ready <= grant_oh;
        xfer_data <= grant_data;
        xfer_src  <= grant_idx;
        xfer_req  <= ~xfer_req;
        rr_ptr    <= (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
      end
`ifdef CDC_XFER_TIMEOUT_EN
      // A lost ack leaves the toggle pair misaligned; force agreement so the next transfer starts clean.
      if (timeout_hit) begin
        ack_s1 <= xfer_req;
        ack_s2 <= xfer_req;
      end
`endif
    end
  end

`ifdef CDC_XFER_TIMEOUT_EN
  always_ff @(posedge src_clk) begin
    if (src_rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (start_xfer) begin
        wd_cnt <= '0;
      end else if (state_q == WAIT_ACK) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end
`endif

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Bench for cdc_xfer_arbiter: table of transfers plus reset and watchdog sequences.
// Covers the CDC_XFER_TIMEOUT_EN build when that macro is defined.
module tb_cdc_xfer_arbiter;

  logic        src_clk;
  logic        src_rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        xfer_req;
  logic [7:0]  xfer_data;
  logic [1:0]  xfer_src;
  logic        xfer_ack_async;
  logic        xfer_done;
  logic        busy;
`ifdef CDC_XFER_TIMEOUT_EN
  logic        timeout_err;
`endif

  cdc_xfer_arbiter #(
    .NUM_REQ       (4),
    .DATA_W        (8),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .src_clk       (src_clk),
    .src_rst       (src_rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .xfer_req      (xfer_req),
    .xfer_data     (xfer_data),
    .xfer_src      (xfer_src),
    .xfer_ack_async(xfer_ack_async),
    .xfer_done     (xfer_done),
    .busy          (busy)
`ifdef CDC_XFER_TIMEOUT_EN
    ,
    .timeout_err   (timeout_err)
`endif
  );

  initial src_clk = 1'b0;
  always #5 src_clk = ~src_clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          src;
  } vec_t;

  typedef struct {
    int         src;
    logic [7:0] data;
    logic       req;
  } exp_t;

  vec_t  vecs[14];
  exp_t  sb_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  exp_req = 1'b0;

  task automatic tick();
    @(posedge src_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_xfer(input logic [3:0] valid, input logic [31:0] data,
                         input int exp_src, input int wait_cyc);
    exp_t       e;
    exp_t       got;
    int         n;
    logic       any_done;
    logic [31:0] dsh;
    dsh     = data >> (exp_src * 8);
    exp_req = ~exp_req;
    e.src   = exp_src;
    e.data  = dsh[7:0];
    e.req   = exp_req;
    sb_q.push_back(e);
    req_valid = valid;
    req_data  = data;
    tick();
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    got = sb_q.pop_front();
    check("req_ready", {28'd0, req_ready}, 32'd1 << got.src);
    check("xfer_src", {30'd0, xfer_src}, got.src);
    check("xfer_data", {24'd0, xfer_data}, {24'd0, got.data});
    check("xfer_req", {31'd0, xfer_req}, {31'd0, got.req});
    check("busy_grant", {31'd0, busy}, 32'd1);
    // Requesters keep churning while the transfer is in flight; none of it may leak through.
    req_valid = 4'hF;
    req_data  = ~data;
    any_done  = 1'b0;
    for (int k = 0; k < wait_cyc; k++) begin
      tick();
      any_done = any_done | xfer_done;
    end
    check("done_early", {31'd0, any_done}, 32'd0);
    check("hold_src", {30'd0, xfer_src}, got.src);
    check("hold_data", {24'd0, xfer_data}, {24'd0, got.data});
    check("hold_req", {31'd0, xfer_req}, {31'd0, got.req});
    check("hold_ready", {28'd0, req_ready}, 32'd0);
    xfer_ack_async = exp_req;
    n = 0;
    while (!xfer_done && n < 10) begin
      tick();
      n++;
    end
    n_tests++;
    if (!(n >= 2 && n <= 3)) begin
      n_fail++;
      $display("FAIL done_latency: got %0d cycles, expected 2..3", n);
    end
    check("no_grant_with_done", {28'd0, req_ready}, 32'd0);
    check("data_at_done", {24'd0, xfer_data}, {24'd0, got.data});
    req_valid = 4'h0;
    tick();
    check("done_pulse_width", {31'd0, xfer_done}, 32'd0);
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0]  = '{4'b0001, 32'h0000_00A5, 0};
    vecs[1]  = '{4'b1111, 32'h4433_2211, 1};
    vecs[2]  = '{4'b1111, 32'h4837_2615, 2};
    vecs[3]  = '{4'b1111, 32'h9C8B_7A69, 3};
    vecs[4]  = '{4'b1111, 32'hF0E1_D2C3, 0};
    vecs[5]  = '{4'b1111, 32'h0F1E_2D3C, 1};
    vecs[6]  = '{4'b1111, 32'h55AA_55AA, 2};
    vecs[7]  = '{4'b1111, 32'h1234_5678, 3};
    vecs[8]  = '{4'b1001, 32'hDEAD_BEEF, 0};
    vecs[9]  = '{4'b1001, 32'hCAFE_F00D, 3};
    vecs[10] = '{4'b0100, 32'h00C3_0000, 2};
    vecs[11] = '{4'b0100, 32'h003C_0000, 2};
    vecs[12] = '{4'b0010, 32'h0000_5A00, 1};
    vecs[13] = '{4'b0011, 32'h0000_00E7, 0};

    src_rst        = 1'b1;
    req_valid      = 4'h0;
    req_data       = 32'h0;
    xfer_ack_async = 1'b0;
    tick();
    check("rst_xfer_req", {31'd0, xfer_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_xfer_done", {31'd0, xfer_done}, 32'd0);
    check("rst_xfer_data", {24'd0, xfer_data}, 32'd0);
    check("rst_xfer_src", {30'd0, xfer_src}, 32'd0);
`ifdef CDC_XFER_TIMEOUT_EN
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
`endif
    tick();
    src_rst = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) begin
      do_xfer(vecs[i].valid, vecs[i].data, vecs[i].src, 2 + (i % 3));
    end

`ifdef CDC_XFER_TIMEOUT_EN
    begin
      int n;
      req_valid = 4'b0010;
      req_data  = 32'h0000_7700;
      exp_req   = ~exp_req;
      tick();
      check("to_req_ready", {28'd0, req_ready}, 32'b0010);
      check("to_xfer_req", {31'd0, xfer_req}, {31'd0, exp_req});
      req_valid = 4'h0;
      n = 0;
      while (!xfer_done && n < 20) begin
        tick();
        n++;
      end
      check("to_done_cycles", n, 32'd8);
      check("to_err_set", {31'd0, timeout_err}, 32'd1);
      check("to_xfer_done", {31'd0, xfer_done}, 32'd1);
      xfer_ack_async = exp_req;
      tick();
      check("to_busy_after", {31'd0, busy}, 32'd0);
      do_xfer(4'b0001, 32'h0000_003C, 0, 3);
      check("to_err_sticky", {31'd0, timeout_err}, 32'd1);
    end
`else
    do_xfer(4'b0010, 32'h0000_6900, 1, 80);
`endif

    req_valid = 4'b0100;
    req_data  = 32'h0081_0000;
    exp_req   = ~exp_req;
    tick();
    check("pre_rst_ready", {28'd0, req_ready}, 32'b0100);
    check("pre_rst_xfer_req", {31'd0, xfer_req}, {31'd0, exp_req});
    req_valid = 4'hF;
    tick();
    tick();
    src_rst = 1'b1;
    tick();
    check("mid_rst_xfer_req", {31'd0, xfer_req}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, xfer_done}, 32'd0);
    check("mid_rst_ready", {28'd0, req_ready}, 32'd0);
    tick();
    check("hold_rst_busy", {31'd0, busy}, 32'd0);
    check("hold_rst_data", {24'd0, xfer_data}, 32'd0);
    check("hold_rst_src", {30'd0, xfer_src}, 32'd0);
    check("hold_rst_done", {31'd0, xfer_done}, 32'd0);
    src_rst        = 1'b0;
    xfer_ack_async = 1'b0;
    exp_req        = 1'b0;
    req_valid      = 4'h0;
    tick();
    check("post_rst_done", {31'd0, xfer_done}, 32'd0);
    do_xfer(4'b1111, 32'hB4B3_B2B1, 0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdc_xfer_arbiter.md
CDC_XFER_ARBITER -- requirements
Module: cdc_xfer_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters (2..8).
REQ-002 Parameter DATA_W, 8, payload width.
REQ-003 Parameter TIMEOUT_CYCLES, 64, ack watchdog limit (used only with the macro in REQ-030).
REQ-004 Port src_clk  in  1  sole clock; all logic on the rising edge.
REQ-005 Port src_rst  in  1  synchronous, active-high reset.
REQ-006 Port req_valid  in  NUM_REQ  per-requester transfer request, held until accepted.
REQ-007 Port req_data  in  NUM_REQ*DATA_W  per-requester payload; slice i belongs to requester i.
REQ-008 Port req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester.
REQ-009 Port xfer_req  out  1  toggle-handshake request level to the destination domain.
REQ-010 Port xfer_data  out  DATA_W  registered payload, stable while a transfer is in flight.
REQ-011 Port xfer_src  out  clog2(NUM_REQ)  index of the requester owning the in-flight payload.
REQ-012 Port xfer_ack_async  in  1  toggle ack from the destination domain; asynchronous to src_clk.
REQ-013 Port xfer_done  out  1  one-cycle pulse on transfer completion.
REQ-014 Port busy  out  1  high while state is not IDLE.

Function
REQ-015 xfer_ack_async SHALL pass through a two-flop synchronizer (ack_s1, ack_s2) before any use; no other logic reads it.
REQ-016 FSM states SHALL be IDLE and WAIT_ACK only.
REQ-017 In IDLE with any req_valid set, the block SHALL grant exactly one requester, chosen round-robin starting at the index after the last grant.
REQ-018 On the grant edge, the block SHALL pulse req_ready[g] for one cycle, register req_data slice g into xfer_data and g into xfer_src, invert xfer_req, and enter WAIT_ACK.
REQ-019 Grant latency SHALL be one cycle: req_valid sampled high in IDLE gives req_ready and the new xfer_req on the next edge.
REQ-020 In WAIT_ACK, the transfer SHALL complete when ack_s2 equals xfer_req; the block then pulses xfer_done for one cycle and returns to IDLE.
REQ-021 xfer_data, xfer_src and xfer_req SHALL NOT change while in WAIT_ACK.
REQ-022 A new grant SHALL NOT occur in the same cycle as xfer_done; the earliest next grant is the cycle after.
REQ-023 req_valid changes while in WAIT_ACK SHALL be ignored until IDLE.
REQ-024 The round-robin pointer SHALL wrap from NUM_REQ-1 to 0.
REQ-025 With a single active requester, that requester SHALL be granted on every IDLE visit.

Reset
REQ-026 On src_rst, the block SHALL set the state to IDLE and clear xfer_req, ack_s1, ack_s2, xfer_data, xfer_src, req_ready, xfer_done, busy and timeout_err. The pointer SHALL reset so that requester 0 has highest priority.
REQ-027 Reset during WAIT_ACK SHALL abandon the transfer with no xfer_done pulse. The destination side SHALL be reset together with this block.
REQ-028 Outputs SHALL reach their reset values on the first edge with src_rst high and stay there while src_rst is held high.

Configuration
REQ-029 Macro CDC_XFER_TIMEOUT_EN SHALL enable the ack watchdog.
REQ-030 With CDC_XFER_TIMEOUT_EN defined:
- add output port timeout_err (1 bit, sticky, cleared only by reset);
- a counter SHALL clear on entry to WAIT_ACK and increment each cycle in WAIT_ACK;
- when the counter reaches TIMEOUT_CYCLES with no ack, the block SHALL set timeout_err, pulse xfer_done, return to IDLE, and load ack_s1 and ack_s2 with xfer_req to realign the toggle pair.
REQ-031 Without CDC_XFER_TIMEOUT_EN, there SHALL be no timeout_err port and no counter logic, and WAIT_ACK SHALL be held indefinitely.

Verification
REQ-032 Reset, then req_valid=4'b0001 with data 0xA5:
- req_ready[0] pulses one cycle later;
- xfer_req goes 0->1, xfer_data=0xA5, xfer_src=0;
- toggle ack to 1, and xfer_done pulses 2-3 cycles later.
REQ-033 req_valid=4'b1111 held:
- grants SHALL occur in order 0,1,2,3,0;
- each grant occurs only after the previous xfer_done;
- xfer_req alternates level on each grant.
REQ-034 Last grant was 3, then req_valid=4'b1001: the next grant SHALL go to 0 (wrap), then to 3.
REQ-035 Assert src_rst during WAIT_ACK:
- the next edge shows xfer_req=0, busy=0 and no xfer_done;
- the first post-reset grant goes to requester 0.
REQ-036 With CDC_XFER_TIMEOUT_EN and TIMEOUT_CYCLES=8, never toggle ack:
- timeout_err=1 and xfer_done pulses 8 cycles after entry to WAIT_ACK;
- a following transfer completes normally on a proper ack.
REQ-037 Change req_data and req_valid while in WAIT_ACK: xfer_data and xfer_src SHALL remain at their granted values until xfer_done.
